jtag_axi_arb: RTL
=================

JTAG_AXI_ARB -- requirements
Module: jtag_axi_arb

Interface
REQ-001 Parameter TIMEOUT, default 1024, SHALL give the maximum number of WAIT cycles before a transaction is aborted with error (legal range 2..65535).
REQ-002 clk_i  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_i  in  1  reset, asynchronous, active-high.
REQ-004 req_valid_i  in  2  per-requester command valid (index 0, 1).
REQ-005 req_ready_o  out  2  per-requester command accept.
REQ-006 req_we_i  in  2  per-requester direction: 1 = store, 0 = load.
REQ-007 req_addr_i  in  2x32  per-requester byte address; bits [2:0] SHALL be ignored.
REQ-008 req_wdata_i  in  2x64  per-requester store data.
REQ-009 rsp_valid_o  out  2  per-requester one-cycle completion pulse.
REQ-010 rsp_rdata_o  out  64  load data, shared, valid with rsp_valid_o.
REQ-011 rsp_err_o  out  1  timeout flag, shared, valid with rsp_valid_o.
REQ-012 upd_o  out  1  one-cycle update strobe to the JTAG-AXI bridge.
REQ-013 axireg_o  out  96  bridge command word.
REQ-014 done_i  in  1  bridge completion pulse.
REQ-015 rdata_i  in  64  bridge load data, sampled with done_i.

Function
REQ-016 The FSM SHALL have states IDLE, ISSUE, WAIT and RESP.
REQ-017 IDLE: when any req_valid_i bit is set, one requester SHALL be granted, req_ready_o of that requester alone SHALL be 1 in that same cycle (combinational from req_valid_i), its we/addr/wdata SHALL be captured, and the FSM SHALL enter ISSUE.
REQ-018 Arbitration SHALL be round-robin: with both valid, the requester not granted last wins; with one valid, it wins regardless of history.
REQ-019 req_ready_o SHALL be 0 in every state other than IDLE; a requester SHALL hold valid and fields stable until ready.
REQ-020 ISSUE: upd_o SHALL be 1 for exactly one cycle, then the FSM SHALL enter WAIT with the timeout counter cleared.
REQ-021 axireg_o SHALL be {wdata[63:0], addr[31:3], 1'b0, we, 1'b1} in ISSUE and WAIT, and all-zero in IDLE and RESP.
REQ-022 WAIT: done_i=1 SHALL capture rdata_i (load) or 64'h0 (store), set err=0 and enter RESP.
REQ-023 WAIT without done_i: the counter SHALL increment; in the cycle the counter equals TIMEOUT-1, err=1 and rdata=0 SHALL be captured and the FSM SHALL enter RESP.
REQ-024 done_i and timeout in the same cycle: done_i SHALL win (err=0).
REQ-025 done_i outside WAIT SHALL be ignored.
REQ-026 RESP: rsp_valid_o of the granted requester SHALL pulse for one cycle with rsp_rdata_o/rsp_err_o; the last-grant pointer SHALL update; the FSM SHALL return to IDLE with no back-pressure.
REQ-027 rsp_rdata_o and rsp_err_o SHALL hold their captured values until the next RESP.
REQ-028 Minimum transaction latency, grant to rsp_valid_o, SHALL be 3 cycles (done_i in the first WAIT cycle); maximum throughput is one transaction per 4 cycles.

Reset
REQ-029 rst_i=1 SHALL immediately force: state IDLE; req_ready_o, rsp_valid_o, upd_o, rsp_err_o = 0; axireg_o, rsp_rdata_o = 0; counter = 0; last-grant = requester 1, so requester 0 wins first.
REQ-030 Reset during ISSUE/WAIT/RESP SHALL drop the transaction with no rsp_valid_o; a done_i arriving after reset release SHALL be ignored.

Verification
REQ-031 Single load: req0 addr 0x1000_0008, we=0 -> upd_o pulse one cycle after grant, axireg_o[31:0]=0x1000_0009; done_i with rdata_i=0xDEAD_BEEF_0123_4567 -> rsp_valid_o=2'b01 next cycle, same rdata, err=0.
REQ-032 Store: req1 addr 0x2000_0007, wdata 0x1122_3344_5566_7788, we=1 -> axireg_o={0x1122334455667788, 0x2000_0003}; done_i -> rsp_valid_o=2'b10, rdata=0, err=0.
REQ-033 Contention: both valid continuously out of reset -> grants 0,1,0,1; no requester granted twice in a row.
REQ-034 Timeout: TIMEOUT=8, done_i never -> rsp_valid_o exactly 8 WAIT cycles after entering WAIT, rsp_err_o=1, rdata=0; done_i in that same cycle -> err=0.
REQ-035 Reset mid-WAIT: assert rst_i 3 cycles into WAIT -> all outputs 0 asynchronously, no rsp_valid_o, subsequent stray done_i ignored, next request granted to requester 0.

Source files
------------

// File: rtl/jtag_axi_arb.sv
// Two-requester round-robin arbiter in front of a JTAG-AXI bridge.
// A granted command is presented to the bridge as a 96-bit word with a one-cycle update
// strobe. The arbiter then waits for the bridge completion or a timeout, and returns a
// one-cycle response pulse to the requester that was granted.
//
// Ports:
//   clk_i, rst_i        clock, asynchronous active-high reset
//   req_valid_i/ready_o per-requester command handshake (index 0, 1)
//   req_we_i            1 = store, 0 = load
//   req_addr_i          {addr1, addr0}, 32 bits each, bits [2:0] ignored
//   req_wdata_i         {wdata1, wdata0}, 64 bits each
//   rsp_valid_o         per-requester completion pulse
//   rsp_rdata_o/err_o   shared response data / timeout flag, held until the next response
//   upd_o, axireg_o     bridge update strobe and command word
//   done_i, rdata_i     bridge completion pulse and load data
module jtag_axi_arb #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [1:0]   req_valid_i,
  output logic [1:0]   req_ready_o,
  input  logic [1:0]   req_we_i,
  input  logic [63:0]  req_addr_i,
  input  logic [127:0] req_wdata_i,
  output logic [1:0]   rsp_valid_o,
  output logic [63:0]  rsp_rdata_o,
  output logic         rsp_err_o,
  output logic         upd_o,
  output logic [95:0]  axireg_o,
  input  logic         done_i,
  input  logic [63:0]  rdata_i
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  localparam logic [15:0] CntMax = 16'(TIMEOUT - 1);

  state_e        state_q, state_d;
  logic          gnt_q, gnt_d;
  logic          last_q, last_d;
  logic          we_q, we_d;
  logic [28:0]   addr_q, addr_d;
  logic [63:0]   wdata_q, wdata_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [63:0]   rdata_q, rdata_d;
  logic          err_q, err_d;

  logic          sel;
  logic [1:0]    ready;
  logic [1:0]    rsp_valid;
  logic [95:0]   cmd;

  // Address bits [2:0] are not part of the bridge command.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^{req_addr_i[34:32], req_addr_i[2:0]};

  // Requester 1 wins only if it is valid and either alone or requester 0 was served last.
  assign sel = req_valid_i[1] & (~req_valid_i[0] | ~last_q);
  assign cmd = {wdata_q, addr_q, 1'b0, we_q, 1'b1};

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    last_d    = last_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    ready     = 2'b00;
    rsp_valid = 2'b00;
    upd_o     = 1'b0;
    axireg_o  = '0;
    unique case (state_q)
      StIdle: begin
        if (|req_valid_i) begin
          ready[sel] = 1'b1;
          gnt_d      = sel;
          we_d       = req_we_i[sel];
          addr_d     = sel ? req_addr_i[63:35] : req_addr_i[31:3];
          wdata_d    = sel ? req_wdata_i[127:64] : req_wdata_i[63:0];
          state_d    = StIssue;
        end
      end
      StIssue: begin
        upd_o    = 1'b1;
        axireg_o = cmd;
        cnt_d    = '0;
        state_d  = StWait;
      end
      StWait: begin
        axireg_o = cmd;
        // Completion takes priority over a timeout in the same cycle.
        if (done_i) begin
          rdata_d = we_q ? 64'h0 : rdata_i;
          err_d   = 1'b0;
          state_d = StResp;
        end else if (cnt_q == CntMax) begin
          rdata_d = 64'h0;
          err_d   = 1'b1;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StResp: begin
        rsp_valid[gnt_q] = 1'b1;
        last_d           = gnt_q;
        state_d          = StIdle;
      end
    endcase
  end

  // Ready is combinational from valid, so it must also be masked by reset directly.
  assign req_ready_o = rst_i ? 2'b00 : ready;
  assign rsp_valid_o = rsp_valid;
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

endmodule
